inst_decode_stage: RTL and testbench
====================================

INST_DECODE_STAGE -- requirements
Module: inst_decode_stage

Interface
REQ-001 Parameter cStages, default 2, meaning register stages from input to output (legal values 1 or 2).
REQ-002 Parameter cChkIllegal, default 1, meaning illegal-instruction detection enabled (0: oIllegal tied 0).
REQ-003 iClk  input  1  clock; all logic on its rising edge.
REQ-004 iRst  input  1  reset, synchronous and active-low.
REQ-005 iValid  input  1  iInst/iPc valid this cycle.
REQ-006 oReady  output  1  stage accepts input this cycle.
REQ-007 iInst  input  32  raw RV32I instruction.
REQ-008 iPc  input  32  instruction address.
REQ-009 iFlush  input  1  discard all in-flight instructions.
REQ-010 oValid  output  1  oDecoded/oPc/oIllegal valid.
REQ-011 iReady  input  1  consumer accepts output this cycle.
REQ-012 oDecoded  output  tDecodedInst  decoded fields, each with valid bit.
REQ-013 oPc  output  32  address travelling with oDecoded.
REQ-014 oIllegal  output  1  instruction is illegal; qualified by oValid.

Function
REQ-015 A transfer occurs on input when iValid&&oReady, on output when oValid&&iReady; nothing else moves data.
REQ-016 Each stage holds one entry plus a valid bit; a stage loads when empty or when its content moves on in the same cycle.
REQ-017 oReady = !valid(first stage) || first stage advancing; combinational from iReady only through the valid chain.
REQ-018 With no back-pressure, latency is exactly cStages cycles from input transfer to oValid; throughput one per cycle.
REQ-019 With iReady low, the output entry is held stable and unmodified; upstream entries fill; no entry is dropped or duplicated, order preserved.
REQ-020 iFlush high clears every stage valid at the next edge; an input offered in the flush cycle is discarded; iFlush has priority over all transfers.
REQ-021 oDecoded.opcode carries iInst[6:0]; rs1/rs2/rd/funct3/funct7 carry {field,1'b1} only for formats that use them, else all-zero.
REQ-022 Immediates sign-extended from inst[31] to 32 bits: I (load, op-imm, jalr), S, B (bit0=0), U (low 12 zero), J (bit0=0); imm.dv=1 for every format with an immediate, including jalr.
REQ-023 Fence and system opcodes: opcode only, all other fields zero, not illegal.
REQ-024 Illegal when: inst[1:0]!=2'b11; opcode not in tOpcodeEnum; load funct3 in {011,110,111}; store funct3>=011; branch funct3 in {010,011}; jalr funct3!=000; R-type funct7 not 0000000/0100000, or 0100000 with funct3 not in {000,101}; op-imm shift funct7 not 0000000 (funct3 001) or not in {0000000,0100000} (funct3 101).
REQ-025 Illegal entry: oIllegal=1, all oDecoded field valid bits and imm.dv zero, oPc still valid.
REQ-026 Opcode/field decode is in the first stage; immediate formation and illegal check complete before the last stage register.

Reset
REQ-027 While iRst low at an edge: all stage valids 0, oValid 0, oDecoded all-zero, oPc 0, oIllegal 0; oReady 1 from the first cycle after reset.
REQ-028 Reset mid-stream discards all in-flight entries; no output from pre-reset inputs ever appears.

Structure
REQ-029 tDecodedInst, tOpcodeEnum, cRegSelBitW, and the new tImmFmt enum and funct3/funct7 legal-value constants live in corePckg.
REQ-030 Immediate extraction/sign extension is one combinational sub-module, imm_gen (inputs inst, tImmFmt; output 32-bit imm).

Verification
REQ-031 addi x1,x2,-1 (0xFFF10093), iReady=1 -> after cStages cycles rs1={2,1}, rd={1,1}, funct3={0,1}, imm=0xFFFFFFFF, dv=1, oIllegal=0.
REQ-032 beq x1,x2,-4 (0xFE208EE3) -> rs1={1,1}, rs2={2,1}, imm=0xFFFFFFFC, dv=1, rd valid=0.
REQ-033 Stream 3 instructions with iReady low 4 cycles -> oReady drops after cStages accepted, output held stable, all 3 emerge in order after iReady rises.
REQ-034 0x00000000 and R-type funct7=0000001 -> oValid with oIllegal=1, all field valids 0.
REQ-035 iFlush with 2 in flight and iValid high -> next cycle oValid=0, flushed and offered instructions never appear.
REQ-036 iRst low for 1 cycle mid-stream -> outputs zero next edge, oReady=1, following instruction decodes with nominal latency.

Source files
------------

// File: rtl/inst_decode_stage_pkg.sv
// Shared decode types: opcodes, immediate formats, decoded bundle.
// Legal funct3/funct7 values and the legality/field helpers live here too.
package corePckg;

  localparam int cRegSelBitW = 5;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_FENCE  = 7'b0001111,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111,
    OPC_SYSTEM = 7'b1110011
  } tOpcodeEnum;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } tImmFmt;

  localparam logic [2:0] cF3Add  = 3'b000;
  localparam logic [2:0] cF3Sl   = 3'b001;
  localparam logic [2:0] cF3Sr   = 3'b101;
  localparam logic [6:0] cF7Base = 7'b0000000;
  localparam logic [6:0] cF7Alt  = 7'b0100000;

  typedef struct packed {
    logic [cRegSelBitW-1:0] sel;
    logic                   v;
  } tRegSel;

  typedef struct packed {
    logic [2:0] val;
    logic       v;
  } tFunct3;

  typedef struct packed {
    logic [6:0] val;
    logic       v;
  } tFunct7;

  typedef struct packed {
    logic [31:0] d;
    logic        dv;
  } tImm;

  typedef struct packed {
    logic [6:0] opcode;
    tRegSel     rs1;
    tRegSel     rs2;
    tRegSel     rd;
    tFunct3     funct3;
    tFunct7     funct7;
    tImm        imm;
  } tDecodedInst;

  function automatic tImmFmt dec_fmt(
    input logic [6:0] op
  );
    tImmFmt f;
    f = IMM_NONE;
    unique case (1'b1)
      op == OPC_LOAD,
      op == OPC_OP_IMM,
      op == OPC_JALR:   f = IMM_I;
      op == OPC_STORE:  f = IMM_S;
      op == OPC_BRANCH: f = IMM_B;
      op == OPC_LUI,
      op == OPC_AUIPC:  f = IMM_U;
      op == OPC_JAL:    f = IMM_J;
      default:          f = IMM_NONE;
    endcase
    return f;
  endfunction

  function automatic tDecodedInst dec_fields(
    input logic [31:0] inst
  );
    tDecodedInst d;
    logic [6:0]  op;
    logic        urd, ur1, ur2, uf3, uf7;
    op = inst[6:0];
    d  = '0;
    d.opcode = op;
    {urd, ur1, ur2, uf3, uf7} = '0;
    unique case (1'b1)
      op == OPC_LUI,
      op == OPC_AUIPC,
      op == OPC_JAL:    urd = 1'b1;
      op == OPC_JALR,
      op == OPC_LOAD,
      op == OPC_OP_IMM: {urd, ur1, uf3} = '1;
      op == OPC_BRANCH,
      op == OPC_STORE:  {ur1, ur2, uf3} = '1;
      op == OPC_OP:     {urd, ur1, ur2, uf3, uf7} = '1;
      default:          urd = 1'b0;
    endcase
    if (urd) d.rd     = {inst[11:7], 1'b1};
    if (ur1) d.rs1    = {inst[19:15], 1'b1};
    if (ur2) d.rs2    = {inst[24:20], 1'b1};
    if (uf3) d.funct3 = {inst[14:12], 1'b1};
    if (uf7) d.funct7 = {inst[31:25], 1'b1};
    return d;
  endfunction

  function automatic logic is_illegal(
    input logic [31:0] inst
  );
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic       bad;
    op  = inst[6:0];
    f3  = inst[14:12];
    f7  = inst[31:25];
    bad = 1'b0;
    unique case (1'b1)
      op == OPC_LOAD:
        bad = f3 inside {3'b011, 3'b110, 3'b111};
      op == OPC_STORE:  bad = f3 >= 3'b011;
      op == OPC_BRANCH: bad = f3 inside {3'b010, 3'b011};
      op == OPC_JALR:   bad = f3 != cF3Add;
      op == OPC_OP:
        bad = !(f7 == cF7Base ||
                (f7 == cF7Alt &&
                 (f3 == cF3Add || f3 == cF3Sr)));
      op == OPC_OP_IMM:
        bad = (f3 == cF3Sl && f7 != cF7Base) ||
              (f3 == cF3Sr && f7 != cF7Base &&
               f7 != cF7Alt);
      op == OPC_LUI,
      op == OPC_AUIPC,
      op == OPC_JAL,
      op == OPC_FENCE,
      op == OPC_SYSTEM: bad = 1'b0;
      default:          bad = 1'b1;
    endcase
    return bad || (inst[1:0] != 2'b11);
  endfunction

endpackage

// File: rtl/inst_decode_stage_if.sv
// Fetch-side and consumer-side handshake bundle of the decode stage.
// slave is the stage's view, master the surrounding pipeline's.
interface inst_decode_stage_if;
  import corePckg::*;

  logic        iValid;
  logic        oReady;
  logic [31:0] iInst;
  logic [31:0] iPc;
  logic        iFlush;
  logic        oValid;
  logic        iReady;
  tDecodedInst oDecoded;
  logic [31:0] oPc;
  logic        oIllegal;

  modport slave (
    input  iValid, iInst, iPc, iFlush, iReady,
    output oReady, oValid, oDecoded, oPc, oIllegal
  );

  modport master (
    output iValid, iInst, iPc, iFlush, iReady,
    input  oReady, oValid, oDecoded, oPc, oIllegal
  );

endinterface

// File: rtl/inst_decode_stage_imm_gen.sv
// RV32I immediate extraction and sign extension for one format.
// Opcode bits are not needed, so only inst[31:7] comes in.
module imm_gen
  import corePckg::*;
(
  input  logic [31:7] inst,
  input  tImmFmt      fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    unique case (fmt)
      IMM_I: imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S: imm = {{20{inst[31]}},
                    inst[31:25], inst[11:7]};
      IMM_B: imm = {{19{inst[31]}}, inst[31],
                    inst[7], inst[30:25],
                    inst[11:8], 1'b0};
      IMM_U: imm = {inst[31:12], 12'b0};
      IMM_J: imm = {{11{inst[31]}}, inst[31],
                    inst[19:12], inst[20],
                    inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/inst_decode_stage.sv
// RV32I decode pipeline with 1 or 2 elastic register stages.
// Fields decode up front; immediate and legality feed the output register.
module inst_decode_stage
  import corePckg::*;
#(
  parameter int cStages     = 2,
  parameter bit cChkIllegal = 1
) (
  input logic                iClk,
  input logic                iRst,
  inst_decode_stage_if.slave bus
);

  logic        ov, oill;
  logic [31:0] opc;
  tDecodedInst odec;

  logic        inRdy, canLoad, lastLoad;
  logic        lstVld;
  logic [31:0] lstInst, lstPc;
  tDecodedInst lstDec;
  tImmFmt      lstFmt;

  logic        nxtIll;
  logic [31:0] nxtImm;
  tDecodedInst nxtDec;

  assign canLoad  = !ov || bus.iReady;
  assign lastLoad = lstVld && canLoad;

  if (cStages == 2) begin : g_two
    logic        s1v;
    logic [31:0] s1inst, s1pc;
    tDecodedInst s1dec;
    tImmFmt      s1fmt;
    logic        inXfer;

    assign inXfer = bus.iValid && inRdy;
    assign inRdy  = !s1v || canLoad;

    always_ff @(posedge iClk) begin
      if (!iRst) begin
        s1v    <= 1'b0;
        s1inst <= '0;
        s1pc   <= '0;
        s1dec  <= '0;
        s1fmt  <= IMM_NONE;
      end else begin
        if (bus.iFlush)   s1v <= 1'b0;
        else if (inXfer)  s1v <= 1'b1;
        else if (canLoad) s1v <= 1'b0;
        if (inXfer) begin
          s1inst <= bus.iInst;
          s1pc   <= bus.iPc;
          s1dec  <= dec_fields(bus.iInst);
          s1fmt  <= dec_fmt(bus.iInst[6:0]);
        end
      end
    end

    assign lstVld  = s1v;
    assign lstInst = s1inst;
    assign lstPc   = s1pc;
    assign lstDec  = s1dec;
    assign lstFmt  = s1fmt;
  end else begin : g_one
    assign inRdy   = canLoad;
    assign lstVld  = bus.iValid;
    assign lstInst = bus.iInst;
    assign lstPc   = bus.iPc;
    assign lstDec  = dec_fields(bus.iInst);
    assign lstFmt  = dec_fmt(bus.iInst[6:0]);
  end

  imm_gen u_imm (
    .inst (lstInst[31:7]),
    .fmt  (lstFmt),
    .imm  (nxtImm)
  );

  assign nxtIll = cChkIllegal ?
                  is_illegal(lstInst) : 1'b0;

  // Illegal entries keep only the opcode
  always_comb begin
    nxtDec     = lstDec;
    nxtDec.imm = {nxtImm, lstFmt != IMM_NONE};
    if (nxtIll) begin
      nxtDec        = '0;
      nxtDec.opcode = lstInst[6:0];
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      ov   <= 1'b0;
      odec <= '0;
      opc  <= '0;
      oill <= 1'b0;
    end else begin
      if (bus.iFlush)        ov <= 1'b0;
      else if (lastLoad)     ov <= 1'b1;
      else if (bus.iReady)   ov <= 1'b0;
      if (lastLoad) begin
        odec <= nxtDec;
        opc  <= lstPc;
        oill <= nxtIll;
      end
    end
  end

  assign bus.oReady   = inRdy;
  assign bus.oValid   = ov;
  assign bus.oDecoded = odec;
  assign bus.oPc      = opc;
  assign bus.oIllegal = oill;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Random and directed stimulus for inst_decode_stage against an
// arithmetic decode model and an in-order queue of accepted entries.
module tb_inst_decode_stage;
  import corePckg::*;

  localparam int cStages = 2;

  typedef struct packed {
    tDecodedInst d;
    logic        ill;
  } tExp;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    int          k;
  } tEnt;

  logic iClk = 1'b0;
  logic iRst;
  always #5 iClk = ~iClk;

  inst_decode_stage_if b ();

  inst_decode_stage #(
    .cStages     (cStages),
    .cChkIllegal (1'b1)
  ) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (b)
  );

  int  nChk = 0;
  int  nBad = 0;
  int  nEdge = 0;
  int  nOut = 0;
  bit  lastAcc;
  tEnt q[$];

  logic [6:0] ops [11] = '{7'h03, 7'h0f, 7'h13,
    7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67,
    7'h6f, 7'h73};

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    nChk++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic tExp ref_dec(input logic [31:0] i);
    tExp e;
    logic [6:0] op, f7;
    logic [2:0] f3;
    bit urd, ur1, ur2, uf3, uf7, hi;
    int imm;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    {urd, ur1, ur2, uf3, uf7, hi} = '0;
    imm = 0;
    e = '0;
    case (op)
      7'h37, 7'h17: begin
        urd = 1; hi = 1; imm = int'(i & 32'hFFFFF000);
      end
      7'h6f: begin
        urd = 1; hi = 1;
        imm = (i[31] ? -(1 << 20) : 0) +
              (int'(i[19:12]) << 12) +
              (int'(i[20]) << 11) + (int'(i[30:21]) << 1);
      end
      7'h67, 7'h03, 7'h13: begin
        urd = 1; ur1 = 1; uf3 = 1; hi = 1;
        imm = $signed(i) >>> 20;
        if (op == 7'h67) e.ill = (f3 != 0);
        if (op == 7'h03) e.ill = f3 inside {3, 6, 7};
        if (op == 7'h13)
          e.ill = (f3 == 1 && f7 != 0) ||
                  (f3 == 5 && !(f7 inside {0, 7'h20}));
      end
      7'h23: begin
        ur1 = 1; ur2 = 1; uf3 = 1; hi = 1;
        imm = (($signed(i) >>> 20) & ~31) |
              int'(i[11:7]);
        e.ill = f3 >= 3;
      end
      7'h63: begin
        ur1 = 1; ur2 = 1; uf3 = 1; hi = 1;
        imm = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 +
              int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
        e.ill = f3 inside {2, 3};
      end
      7'h33: begin
        urd = 1; ur1 = 1; ur2 = 1; uf3 = 1; uf7 = 1;
        e.ill = !(f7 == 0 ||
                  (f7 == 7'h20 && f3 inside {0, 5}));
      end
      7'h0f, 7'h73: e.ill = 0;
      default: e.ill = 1;
    endcase
    e.d.opcode = op;
    if (!e.ill) begin
      if (urd) e.d.rd = {i[11:7], 1'b1};
      if (ur1) e.d.rs1 = {i[19:15], 1'b1};
      if (ur2) e.d.rs2 = {i[24:20], 1'b1};
      if (uf3) e.d.funct3 = {f3, 1'b1};
      if (uf7) e.d.funct7 = {f7, 1'b1};
      if (hi) e.d.imm = {imm, 1'b1};
    end
    return e;
  endfunction

  function automatic logic [31:0] rnd_inst();
    logic [31:0] i;
    i = $urandom;
    if ($urandom % 8 != 0) i[6:0] = ops[$urandom % 11];
    if (i[6:0] == 7'h33 && $urandom % 2 == 1)
      i[31:25] = ($urandom % 2 == 1) ? 7'h20 : 7'h00;
    return i;
  endfunction

  // One clock cycle: drive, check against model, advance model.
  task automatic cyc(input bit v, input logic [31:0] inst,
                     input logic [31:0] pc, input bit rdy,
                     input bit fl, input bit rst);
    bit  ev, inX, outX;
    tExp r;
    b.iValid = v; b.iInst = inst; b.iPc = pc;
    b.iReady = rdy; b.iFlush = fl; iRst = rst;
    #1;
    ev = q.size() > 0 && (nEdge - q[0].k >= cStages - 1);
    chk("ovalid", b.oValid, ev);
    chk("oready", b.oReady, (q.size() < cStages) || rdy);
    if (ev) begin
      r = ref_dec(q[0].inst);
      chk("dec", b.oDecoded, r.d);
      chk("pc", b.oPc, q[0].pc);
      chk("ill", b.oIllegal, r.ill);
    end
    inX  = v && b.oReady;
    outX = b.oValid && rdy;
    lastAcc = inX && rst && !fl;
    @(posedge iClk);
    nEdge++;
    if (!rst || fl) q.delete();
    else begin
      if (outX) begin void'(q.pop_front()); nOut++; end
      if (inX) q.push_back('{inst, pc, nEdge});
    end
    #1;
  endtask

  task automatic directed(input string tag,
                          input logic [31:0] inst,
                          input tDecodedInst e,
                          input bit ill);
    int lat;
    cyc(1, inst, 32'h200, 1, 0, 1);
    lat = 1;
    while (b.oValid !== 1'b1 && lat < 8) begin
      cyc(0, '0, '0, 1, 0, 1);
      lat++;
    end
    chk({tag, "_lat"}, lat, cStages);
    chk({tag, "_dec"}, b.oDecoded, e);
    chk({tag, "_ill"}, b.oIllegal, ill);
    chk({tag, "_pc"}, b.oPc, 32'h200);
    cyc(0, '0, '0, 1, 0, 1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ov"}, b.oValid, 0);
    chk({tag, "_dec"}, b.oDecoded, '0);
    chk({tag, "_pc"}, b.oPc, 0);
    chk({tag, "_ill"}, b.oIllegal, 0);
    chk({tag, "_rdy"}, b.oReady, 1);
  endtask

  tDecodedInst eAddi, eBeq, eZero, eMul;
  logic [31:0] bpI [3] = '{32'h002081B3, 32'h0020A423,
                           32'h123452B7};
  int idx, n0;

  initial begin
    eAddi = '0;
    eAddi.opcode = 7'h13;
    eAddi.rs1 = '{5'd2, 1'b1};
    eAddi.rd = '{5'd1, 1'b1};
    eAddi.funct3 = '{3'd0, 1'b1};
    eAddi.imm = '{32'hFFFFFFFF, 1'b1};
    eBeq = '0;
    eBeq.opcode = 7'h63;
    eBeq.rs1 = '{5'd1, 1'b1};
    eBeq.rs2 = '{5'd2, 1'b1};
    eBeq.funct3 = '{3'd0, 1'b1};
    eBeq.imm = '{32'hFFFFFFFC, 1'b1};
    eZero = '0;
    eMul = '0;
    eMul.opcode = 7'h33;

    iRst = 1'b0;
    b.iValid = 0; b.iInst = '0; b.iPc = '0;
    b.iReady = 0; b.iFlush = 0;
    repeat (2) @(posedge iClk);
    #1;
    chk_reset("rst");

    directed("addi", 32'hFFF10093, eAddi, 0);
    directed("beq", 32'hFE208EE3, eBeq, 0);
    directed("il0", 32'h00000000, eZero, 1);
    directed("ilmul", 32'h022080B3, eMul, 1);

    idx = 0;
    for (int c = 0; c < 4; c++) begin
      cyc(idx < 3, bpI[idx % 3], 32'h300 + idx, 0, 0, 1);
      if (lastAcc) idx++;
    end
    chk("bp_acc", idx, cStages);
    chk("bp_rdy", b.oReady, 0);
    n0 = nOut;
    for (int c = 0; c < 12 && nOut - n0 < 3; c++) begin
      cyc(idx < 3, bpI[idx % 3], 32'h300 + idx, 1, 0, 1);
      if (lastAcc) idx++;
    end
    chk("bp_out", nOut - n0, 3);

    for (int c = 0; c < 2; c++)
      cyc(1, 32'h00108093 + c, 32'h400 + c, 0, 0, 1);
    cyc(1, 32'h00500113, 32'h408, 1, 1, 1);
    chk("fl_ov", b.oValid, 0);
    n0 = nOut;
    repeat (4) cyc(0, '0, '0, 1, 0, 1);
    chk("fl_out", nOut - n0, 0);

    for (int c = 0; c < 2; c++)
      cyc(1, 32'h00208093 + c, 32'h500 + c, 1, 0, 1);
    cyc(1, 32'h00308093, 32'h508, 1, 0, 0);
    chk_reset("mrst");
    directed("mrst", 32'hFFF10093, eAddi, 0);

    for (int c = 0; c < 3000; c++)
      cyc($urandom % 4 != 0, rnd_inst(), $urandom,
          $urandom % 4 != 0, $urandom % 60 == 0,
          $urandom % 150 != 0);

    $display("test done: total=%0d bad=%0d", nChk, nBad);
    $finish;
  end

endmodule
